// File: rtl/mips_pkg.sv
// Shared ISA constants, ALU selector and decoded-control bundle for the single-cycle MIPS core.
// Extended opcodes exist only when MIPS_EXT_INSN_EN is defined.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
`ifdef MIPS_EXT_INSN_EN
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] FnJr    = 6'h08;
`endif

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_ctrl_e;

  typedef struct packed {
    logic reg_write;
    logic reg_dst;
    logic alu_src;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic jump;
    logic ext_op;     // 1: sign-extend immediate, 0: zero-extend
    logic branch_ne;
    logic link;
    logic jump_reg;
  } ctrl_t;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sign);
    return sign ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/mips_dmem.sv
// Word-addressed data memory: asynchronous read, synchronous write, zeroed at time 0 only.
module mips_dmem #(
  parameter int unsigned Words = 128
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Words)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] dataMem [0:Words-1] = '{default: 32'h0};

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      dataMem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = dataMem[addr_i];

endmodule

// File: rtl/mips_imem.sv
// Read-only instruction store; contents are preloaded hierarchically by a loader or bench.
module mips_imem #(
  parameter int unsigned Words = 128
) (
  input  logic [$clog2(Words)-1:0] addr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] imem [0:Words-1] = '{default: 32'h0};

  assign rdata_o = imem[addr_i];

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, $0 hard-wired to 0.
module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] rf [0:31];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= 32'h0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      rf[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'h0 : rf[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'h0 : rf[raddr_b_i];

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS-subset CPU: inline decoder and ALU around imem, dmem and register file.
// Define MIPS_EXT_INSN_EN to add bne, andi, jal and jr.
module mips_core
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 128,
  parameter int unsigned DMEM_WORDS = 128,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned IAw = $clog2(IMEM_WORDS);
  localparam int unsigned DAw = $clog2(DMEM_WORDS);

  logic [31:0] PC;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] AnInstruction;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        unused_shamt;

  ctrl_t       ctrl;
  alu_ctrl_e   alu_ctrl;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] dm_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        br_taken;

  assign opcode       = AnInstruction[31:26];
  assign rs           = AnInstruction[25:21];
  assign rt           = AnInstruction[20:16];
  assign rd           = AnInstruction[15:11];
  assign funct        = AnInstruction[5:0];
  assign imm          = AnInstruction[15:0];
  assign unused_shamt = ^AnInstruction[10:6];

  mips_imem #(.Words(IMEM_WORDS)) U_IM (
    .addr_i  (PC[IAw+1:2]),
    .rdata_o (AnInstruction)
  );

  always_comb begin
    ctrl     = '0;
    alu_ctrl = AluAdd;
    case (opcode)
      OpRtype: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FnAdd:   alu_ctrl = AluAdd;
          FnSub:   alu_ctrl = AluSub;
          FnAnd:   alu_ctrl = AluAnd;
          FnOr:    alu_ctrl = AluOr;
          FnSlt:   alu_ctrl = AluSlt;
`ifdef MIPS_EXT_INSN_EN
          FnJr: begin
            ctrl.reg_write = 1'b0;
            ctrl.jump_reg  = 1'b1;
          end
`endif
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OpLw: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.ext_op     = 1'b1;
      end
      OpSw: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.ext_op    = 1'b1;
      end
      OpBeq:  ctrl.branch = 1'b1;
      OpAddi: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = 1'b1;
      end
      OpOri: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_ctrl       = AluOr;
      end
      OpJ:    ctrl.jump = 1'b1;
`ifdef MIPS_EXT_INSN_EN
      OpBne: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
      end
      OpAndi: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        alu_ctrl       = AluAnd;
      end
      OpJal: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  mips_regfile U_RF (
    .clk_i     (clk),
    .rst_ni    (rst),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data),
    .we_i      (ctrl.reg_write),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data)
  );

  assign alu_b = ctrl.alu_src ? ext_imm(imm, ctrl.ext_op) : rt_data;

  always_comb begin
    alu_y = 32'h0;
    case (alu_ctrl)
      AluAdd:  alu_y = rs_data + alu_b;
      AluSub:  alu_y = rs_data - alu_b;
      AluAnd:  alu_y = rs_data & alu_b;
      AluOr:   alu_y = rs_data | alu_b;
      AluSlt:  alu_y = {31'h0, $signed(rs_data) < $signed(alu_b)};
      default: alu_y = 32'h0;
    endcase
  end

  // Writes are suppressed while reset is held so a clock during reset cannot corrupt memory.
  mips_dmem #(.Words(DMEM_WORDS)) U_DM (
    .clk_i   (clk),
    .we_i    (ctrl.mem_write & rst),
    .addr_i  (alu_y[DAw+1:2]),
    .wdata_i (rt_data),
    .rdata_o (dm_rdata)
  );

  assign wb_addr = ctrl.link ? 5'd31 : (ctrl.reg_dst ? rd : rt);
  assign wb_data = ctrl.link ? pc_plus4 : (ctrl.mem_to_reg ? dm_rdata : alu_y);

  assign pc_plus4 = PC + 32'd4;
  assign br_taken = ctrl.branch && ((rs_data == rt_data) != ctrl.branch_ne);

  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.jump_reg) begin
      pc_d = rs_data;
    end else if (ctrl.jump) begin
      pc_d = {pc_plus4[31:28], AnInstruction[25:0], 2'b00};
    end else if (br_taken) begin
      pc_d = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC <= RESET_PC;
    end else begin
      PC <= pc_d;
    end
  end

endmodule

// File: tb/tb_mips_core.sv
// Bench for mips_core: ISA-level interpreter model compared every cycle, plus directed literals.
module tb_mips_core;

  localparam int IW = 128;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   run_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] m_imem [0:IW-1];
  logic [31:0] m_dm   [0:DW-1];
  logic [31:0] m_rf   [0:31];
  logic [31:0] m_pc;

  mips_core #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ISA reference model ----------------
  task automatic wr(input int r, input logic [31:0] v);
    if (r != 0) m_rf[r] = v;
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, se, ze, nxt, ea;
    logic [5:0]  op, fn;
    int rs, rt, rd;
    ins = m_imem[(m_pc >> 2) % IW];
    op  = ins[31:26];
    fn  = ins[5:0];
    rs  = int'(ins[25:21]);
    rt  = int'(ins[20:16]);
    rd  = int'(ins[15:11]);
    a   = m_rf[rs];
    b   = m_rf[rt];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0, ins[15:0]};
    ea  = a + se;
    nxt = m_pc + 4;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: wr(rd, a + b);
          6'h22: wr(rd, a - b);
          6'h24: wr(rd, a & b);
          6'h25: wr(rd, a | b);
          6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
`ifdef MIPS_EXT_INSN_EN
          6'h08: nxt = a;
`endif
          default: ;
        endcase
      end
      6'h08: wr(rt, a + se);
      6'h0D: wr(rt, a | ze);
      6'h23: wr(rt, m_dm[(ea >> 2) % DW]);
      6'h2B: m_dm[(ea >> 2) % DW] = b;
      6'h04: if (a == b) nxt = m_pc + 4 + (se << 2);
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
`ifdef MIPS_EXT_INSN_EN
      6'h05: if (a != b) nxt = m_pc + 4 + (se << 2);
      6'h0C: wr(rt, a & ze);
      6'h03: begin
        wr(31, m_pc + 4);
        nxt = {nxt[31:28], ins[25:0], 2'b00};
      end
`endif
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // ---------------- per-cycle compare ----------------
  task automatic compare_all();
    check("pc", dut.PC, m_pc);
    check("instr", dut.AnInstruction, m_imem[(m_pc >> 2) % IW]);
    for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), dut.U_RF.rf[i], m_rf[i]);
    for (int i = 0; i < DW; i++) check($sformatf("dmem[%0d]", i), dut.U_DM.dataMem[i], m_dm[i]);
  endtask

  always @(posedge clk) begin
    if (run_en) begin
      model_step();
      #1;
      compare_all();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_prog();
    for (int i = 0; i < IW; i++) begin
      m_imem[i] = 32'h0;
      dut.U_IM.imem[i] = 32'h0;
    end
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    m_imem[idx] = w;
    dut.U_IM.imem[idx] = w;
  endtask

  task automatic run(input int n);
    run_en = 1'b1;
    repeat (n) @(negedge clk);
    run_en = 1'b0;
  endtask

  // Reset asserted and released inside the low half of a clock, with no edge in between.
  task automatic reset_mid();
    int bad;
    rst = 1'b0;
    #1;
    model_reset();
    check("reset pc", dut.PC, 32'h0);
    bad = 0;
    for (int i = 1; i < 32; i++) if (dut.U_RF.rf[i] !== 32'h0) bad++;
    check("reset rf nonzero count", 32'(bad), 32'h0);
    check("reset instr", dut.AnInstruction, m_imem[0]);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm, off;
    logic [25:0] tgt;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    off = 16'(int'($urandom_range(0, 6)) - 3);
    tgt = 26'($urandom_range(0, IW - 1));
    case ($urandom_range(0, 15))
      0:  return enc_r(rs, rt, rd, 6'h20);
      1:  return enc_r(rs, rt, rd, 6'h22);
      2:  return enc_r(rs, rt, rd, 6'h24);
      3:  return enc_r(rs, rt, rd, 6'h25);
      4:  return enc_r(rs, rt, rd, 6'h2A);
      5:  return enc_i(6'h08, rs, rt, imm);
      6:  return enc_i(6'h0D, rs, rt, imm);
      7:  return enc_i(6'h23, rs, rt, 16'($urandom_range(0, 1023)));
      8:  return enc_i(6'h2B, rs, rt, 16'($urandom_range(0, 1023)));
      9:  return enc_i(6'h04, rs, rt, off);
      10: return {6'h02, tgt};
      11: return enc_i(6'h05, rs, rt, off);
      12: return enc_i(6'h0C, rs, rt, imm);
      13: return {6'h03, tgt};
      14: return enc_r(rs, 5'd0, 5'd0, 6'h08);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    for (int i = 0; i < DW; i++) m_dm[i] = 32'h0;
    #1;
    bad = 0;
    for (int i = 0; i < DW; i++) if (dut.U_DM.dataMem[i] !== 32'h0) bad++;
    check("dmem init nonzero count", 32'(bad), 32'h0);

    // Directed program
    clear_prog();
    put(0,  32'h20020005);  // addi $2,$0,5
    put(1,  32'h2003000C);  // addi $3,$0,12
    put(2,  32'h00432020);  // add  $4,$2,$3
    put(3,  32'hAC040050);  // sw   $4,80($0)
    put(4,  32'h8C050050);  // lw   $5,80($0)
    put(5,  32'h00433022);  // sub  $6,$2,$3
    put(6,  32'h00C2382A);  // slt  $7,$6,$2
    put(7,  32'h20000007);  // addi $0,$0,7
    put(8,  32'h10420002);  // beq  $2,$2,+2
    put(9,  32'h20080063);  // skipped
    put(10, 32'h20080063);  // skipped
    put(11, 32'h10430005);  // beq  $2,$3 (not taken)
    put(12, 32'h08000010);  // j 0x10
    put(16, 32'h08000010);  // j 0x10 (self loop)
    reset_mid();
    check("reset instr literal", dut.AnInstruction, 32'h20020005);

    run(3);
    check("lit rf2", dut.U_RF.rf[2], 32'd5);
    check("lit rf3", dut.U_RF.rf[3], 32'd12);
    check("lit rf4", dut.U_RF.rf[4], 32'd17);
    check("lit pc 0c", dut.PC, 32'h0C);
    check("model rf4", m_rf[4], 32'd17);
    run(2);
    check("lit dmem20", dut.U_DM.dataMem[20], 32'd17);
    check("lit rf5", dut.U_RF.rf[5], 32'd17);
    check("model dmem20", m_dm[20], 32'd17);
    run(3);
    check("lit rf6", dut.U_RF.rf[6], 32'hFFFFFFF9);
    check("lit rf7", dut.U_RF.rf[7], 32'd1);
    check("lit rf0", dut.U_RF.rf[0], 32'd0);
    check("model rf6", m_rf[6], 32'hFFFFFFF9);
    run(1);
    check("lit beq taken pc", dut.PC, 32'h2C);
    run(1);
    check("lit beq not taken pc", dut.PC, 32'h30);
    run(1);
    check("lit j pc", dut.PC, 32'h40);
    check("model j pc", m_pc, 32'h40);
    run(3);
    check("lit stuck pc", dut.PC, 32'h40);
    check("lit skipped rf8", dut.U_RF.rf[8], 32'd0);

    // Counting loop, reset applied mid-cycle with live register state
    clear_prog();
    put(0, 32'h20020005);  // addi $2,$0,5
    put(1, 32'h20210001);  // addi $1,$1,1
    put(2, 32'hAC010050);  // sw   $1,80($0)
    put(3, 32'hAC010054);  // sw   $1,84($0)
    put(4, 32'h10220001);  // beq  $1,$2,+1
    put(5, 32'h08000001);  // j 0x04
    put(6, 32'h08000006);  // j 0x18 (self)
    reset_mid();
    run(40);
    check("loop dmem20", dut.U_DM.dataMem[20], 32'd5);
    check("loop dmem21", dut.U_DM.dataMem[21], 32'd5);
    check("loop pc", dut.PC, 32'h18);
    check("model loop dmem21", m_dm[21], 32'd5);

    // Random programs
    for (int r = 0; r < 2; r++) begin
      clear_prog();
      for (int i = 0; i < IW; i++) put(i, rand_insn());
      reset_mid();
      run(300);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
